// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the r200 5-stage pipeline: arbitrates memory wait,
// EX redirect and load-use hazards, and keeps stall/flush/timeout statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned MEMWAIT_MAX = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_isload,
  input  logic             ex_regwr,
  input  logic [4:0]       ex_rdaddr,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [7:0]       WAIT_MAX = 8'(MEMWAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic       mem_stall;
  logic       lu_hazard;
  logic       rs1_match;
  logic       rs2_match;
  logic       redirect_take;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign rs1_match = id_uses_rs1 & (id_rs1addr == ex_rdaddr);
  assign rs2_match = id_uses_rs2 & (id_rs2addr == ex_rdaddr);
  assign lu_hazard = id_valid & ex_valid & ex_isload & ex_regwr &
                     (ex_rdaddr != 5'd0) & (rs1_match | rs2_match);
  assign state     = cur_state;

  // Hazard arbitration: memory wait beats redirect beats load-use beats FLUSH cleanup.
  always_comb begin
    pc_hold       = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    idex_hold     = 1'b0;
    idex_bubble   = 1'b0;
    exmem_hold    = 1'b0;
    redirect_take = 1'b0;
    nxt_state     = RUN;
    if (rst) begin
      nxt_state = RUN;
    end else if (mem_stall) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      // A pending wrong-path discard must survive the freeze.
      nxt_state  = (cur_state == FLUSH) ? FLUSH : MEMWAIT;
    end else if (ex_redirect) begin
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      redirect_take = 1'b1;
      nxt_state     = FLUSH;
    end else if (lu_hazard) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      nxt_state   = RUN;
    end else if (cur_state == FLUSH) begin
      // Second wrong-path fetch, due to the one-cycle fetch latency.
      ifid_flush = 1'b1;
      nxt_state  = RUN;
    end else begin
      nxt_state = RUN;
    end
  end

  // State register, saturating performance counters and memory-wait watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (pc_hold && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (redirect_take && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((cur_state == MEMWAIT) && (nxt_state != MEMWAIT)) begin
        wait_cnt <= 8'd0;
      end else if ((cur_state == MEMWAIT) && mem_stall && (wait_cnt != 8'hFF)) begin
        wait_cnt <= wait_cnt + 8'd1;
        if ((wait_cnt + 8'd1) == WAIT_MAX) begin
          mem_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expectations are queued by the
// driver and compared at the falling edge against the DUT outputs.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  // Control vector order: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_RED  = 6'b001010;
  localparam logic [5:0] C_FL   = 6'b001000;
  localparam logic [5:0] C_MEM  = 6'b110101;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]    id_rs1addr, id_rs2addr, ex_rdaddr;
  logic          ex_valid, ex_isload, ex_regwr, ex_redirect;
  logic          dmem_req, dmem_ready;
  logic          pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          mem_timeout;

  typedef struct {
    string      tag;
    logic [5:0] ctl;
    logic [1:0] st;
    int         sc;
    int         fc;
    int         to;   // -1: not compared this cycle
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl #(.MEMWAIT_MAX(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_isload(ex_isload), .ex_regwr(ex_regwr),
    .ex_rdaddr(ex_rdaddr), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare queued expectations at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val({e.tag, ".ctl"}, 32'({pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold}), 32'(e.ctl));
      check_val({e.tag, ".state"}, 32'(state), 32'(e.st));
      check_val({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
      check_val({e.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
      if (e.to >= 0) check_val({e.tag, ".mem_timeout"}, 32'(mem_timeout), 32'(e.to));
    end
  end

  task automatic idle_in();
    id_valid = 1'b0; id_rs1addr = 5'd0; id_rs2addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_isload = 1'b0; ex_regwr = 1'b0; ex_rdaddr = 5'd0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic lu_in(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic ld);
    id_valid = 1'b1; id_rs1addr = rs1; id_uses_rs1 = u1;
    id_rs2addr = rs2; id_uses_rs2 = u2;
    ex_valid = 1'b1; ex_isload = ld; ex_regwr = 1'b1; ex_rdaddr = rd;
  endtask

  // Push this cycle's expectation, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] st,
                      input int sc, input int fc, input int to);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc; e.to = to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;

    // Reset forces every control low, even with all hazards present.
    lu_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    ex_redirect = 1'b1; dmem_req = 1'b1;
    step("rst_force", C_NONE, 2'd0, 0, 0, 0);
    rst = 1'b0;
    idle_in();
    step("idle", C_NONE, 2'd0, 0, 0, 0);

    // Load-use on rs2, then x0 and unused-operand exclusions, then rs1 and non-load.
    lu_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step("lu_rs2", C_LU, 2'd0, 0, 0, 0);
    idle_in();
    step("lu_after", C_NONE, 2'd0, 1, 0, 0);
    lu_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step("lu_x0", C_NONE, 2'd0, 1, 0, 0);
    lu_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1);
    step("lu_unused", C_NONE, 2'd0, 1, 0, 0);
    lu_in(5'd9, 5'd9, 1'b1, 5'd3, 1'b1, 1'b1);
    step("lu_rs1", C_LU, 2'd0, 1, 0, 0);
    lu_in(5'd9, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0);
    step("lu_noload", C_NONE, 2'd0, 2, 0, 0);

    // Redirect with a concurrent load-use: redirect wins, then one FLUSH cycle.
    lu_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    ex_redirect = 1'b1;
    step("redir0", C_RED, 2'd0, 2, 0, 0);
    idle_in();
    step("redir1", C_FL, 2'd2, 2, 1, 0);
    step("redir2", C_NONE, 2'd0, 2, 1, 0);

    // Memory wait masks a redirect for 3 cycles; the redirect goes on release.
    ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    step("memred_w0", C_MEM, 2'd0, 2, 1, 0);
    step("memred_w1", C_MEM, 2'd1, 3, 1, 0);
    step("memred_w2", C_MEM, 2'd1, 4, 1, 0);
    dmem_ready = 1'b1;
    step("memred_rel", C_RED, 2'd1, 5, 1, 0);
    idle_in();
    step("memred_fl", C_FL, 2'd2, 5, 2, 0);
    step("memred_run", C_NONE, 2'd0, 5, 2, 0);

    // Memory wait inside FLUSH keeps the pending discard.
    ex_redirect = 1'b1;
    step("flmem_red", C_RED, 2'd0, 5, 2, 0);
    ex_redirect = 1'b0; dmem_req = 1'b1;
    step("flmem_w", C_MEM, 2'd2, 5, 3, 0);
    idle_in();
    step("flmem_fl", C_FL, 2'd2, 6, 3, 0);
    step("flmem_run", C_NONE, 2'd0, 6, 3, 0);

    rst = 1'b1;
    step("rst1", C_NONE, 2'd0, 6, 3, 0);
    rst = 1'b0;
    step("rst1_clr", C_NONE, 2'd0, 0, 0, 0);

    // Timeout with MEMWAIT_MAX=4 and ready withheld for 6 cycles.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step("to_w0", C_MEM, 2'd0, 0, 0, 0);
    step("to_w1", C_MEM, 2'd1, 1, 0, 0);
    step("to_w2", C_MEM, 2'd1, 2, 0, 0);
    step("to_w3", C_MEM, 2'd1, 3, 0, -1);
    step("to_w4", C_MEM, 2'd1, 4, 0, -1);
    step("to_w5", C_MEM, 2'd1, 5, 0, 1);
    dmem_ready = 1'b1;
    step("to_rel", C_NONE, 2'd1, 6, 0, 1);
    idle_in();
    step("to_sticky", C_NONE, 2'd0, 6, 0, 1);
    rst = 1'b1;
    step("to_rst", C_NONE, 2'd0, 6, 0, 1);
    rst = 1'b0;
    step("to_clr", C_NONE, 2'd0, 0, 0, 0);

    // 20 stall cycles saturate a 4-bit stall counter at 15.
    dmem_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("sat_w", C_MEM, (i == 0) ? 2'd0 : 2'd1, (i > 15) ? 15 : i, 0, -1);
    end
    idle_in();
    step("sat_rel", C_NONE, 2'd1, 15, 0, 1);
    step("sat_hold", C_NONE, 2'd0, 15, 0, 1);

    // Reset during FLUSH: no residual flush, counters cleared.
    ex_redirect = 1'b1;
    step("rstfl_red", C_RED, 2'd0, 15, 0, 1);
    ex_redirect = 1'b0;
    rst = 1'b1;
    step("rstfl_rst", C_NONE, 2'd2, 15, 1, 1);
    rst = 1'b0;
    step("rstfl_run", C_NONE, 2'd0, 0, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    check_val("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
